// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl
//   Debounces N_CH raw switch inputs and reports every debounced level change as
//   an event on a valid/ready port.
//   - A SYNC_STAGES-deep synchroniser sits on each raw input.
//   - One shared prescaler produces a single-cycle tick every TICK_PERIOD_10NS clocks.
//   - Each channel runs an early-detect FSM {ZERO, WAIT1, ONE, WAIT0}. The output
//     follows the input as soon as a WAIT state is entered, and is then held for the
//     settle period before the input is re-sampled.
//   - Each debounced change marks the channel pending. Only one event is held per
//     channel. A change that hits an already pending channel sets a sticky overflow flag.
//   - A round-robin arbiter moves one pending channel per cycle into the output register.
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_sw[N_CH]              raw asynchronous switch inputs
//   o_sw_debounced[N_CH]    registered debounced levels
//   o_evt_valid/i_evt_ready event handshake
//   o_evt_ch, o_evt_level   channel and debounced level captured at grant
//   o_evt_overflow          sticky lost-change flag, cleared by i_ovf_clr (set wins)
//   o_evt_time[16]          tick timestamp of the change (DEBOUNCE_SCAN_TIMESTAMP_EN only)
// Build option
//   DEBOUNCE_SCAN_TIMESTAMP_EN  adds the tick counter, the per-channel capture
//                               registers and the o_evt_time port.
module debounce_scan_ctrl #(
  parameter int N_CH             = 4,
  parameter int TICK_PERIOD_10NS = 100_000,
  parameter int SETTLE_TICKS     = 20,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_CH-1:0]         i_sw,
  output logic [N_CH-1:0]         o_sw_debounced,
  output logic                    o_evt_valid,
  input  logic                    i_evt_ready,
  output logic [$clog2(N_CH)-1:0] o_evt_ch,
  output logic                    o_evt_level,
  output logic                    o_evt_overflow,
  input  logic                    i_ovf_clr
`ifdef DEBOUNCE_SCAN_TIMESTAMP_EN
  ,
  output logic [15:0]             o_evt_time
`endif
);

  localparam int CW = $clog2(N_CH);
  localparam int PW = (TICK_PERIOD_10NS > 1) ? $clog2(TICK_PERIOD_10NS) : 1;
  localparam int SW = $clog2(SETTLE_TICKS + 1);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} deb_state_e;

  // Synchroniser: stage 0 takes the raw input, the last stage feeds the FSMs.
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0] s_sw;

  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;

  logic [N_CH-1:0] deb_q, deb_d;
  logic [N_CH-1:0] deb_prev_q;
  logic [N_CH-1:0] chg;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] grant_vec;
  logic [CW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   grant;
  logic            load;
  logic            valid_q, valid_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            level_q, level_d;
  logic            ovf_q, ovf_d;

  assign s_sw = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_sw};
    tick    = (presc_q == PW'(TICK_PERIOD_10NS - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Per-channel debounce FSMs
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    deb_state_e    state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cnt_inc = cnt_q + SW'(tick);
      case (state_q)
        ZERO: begin
          cnt_d = '0;
          if (s_sw[gi]) state_d = WAIT1;
        end
        ONE: begin
          cnt_d = '0;
          if (!s_sw[gi]) state_d = WAIT0;
        end
        WAIT1, WAIT0: begin
          cnt_d = cnt_inc;
          // Leave on the tick that brings the count to SETTLE_TICKS, so the time
          // spent in WAIT is between SETTLE_TICKS-1 and SETTLE_TICKS tick periods.
          if (cnt_inc == SW'(SETTLE_TICKS)) begin
            state_d = s_sw[gi] ? ONE : ZERO;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ZERO;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q <= ZERO;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign deb_d[gi] = (state_d == WAIT1) || (state_d == ONE);
  end

  // Change is seen one cycle after the debounced output moves.
  assign chg = deb_q ^ deb_prev_q;

  // Round-robin search: first pending channel at or after rr_q, wrapping.
  always_comb begin
    logic [CW:0] sum;
    logic        found;
    sum   = '0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum = {1'b0, rr_q} + (CW+1)'(i);
      if (sum >= (CW+1)'(N_CH)) sum = sum - (CW+1)'(N_CH);
      if (!found && pending_q[sum[CW-1:0]]) begin
        found = 1'b1;
        grant = sum[CW-1:0];
      end
    end
  end

  always_comb begin
    logic [CW:0] gnext;
    load = (!valid_q || i_evt_ready) && (|pending_q);
    for (int c = 0; c < N_CH; c++) begin
      grant_vec[c] = load && (grant == CW'(c));
    end
    // A new change on a channel being granted this cycle re-arms it.
    pending_d = (pending_q & ~grant_vec) | chg;
    ovf_d     = (ovf_q & ~i_ovf_clr) | (|(chg & pending_q));

    gnext   = {1'b0, grant} + 1'b1;
    if (gnext >= (CW+1)'(N_CH)) gnext = '0;

    valid_d = valid_q;
    ch_d    = ch_q;
    level_d = level_q;
    rr_d    = rr_q;
    if (load) begin
      valid_d = 1'b1;
      ch_d    = grant;
      level_d = deb_q[grant];
      rr_d    = gnext[CW-1:0];
    end else if (valid_q && i_evt_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q     <= '0;
      presc_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pending_q  <= '0;
      rr_q       <= '0;
      valid_q    <= 1'b0;
      ch_q       <= '0;
      level_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      presc_q    <= presc_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      pending_q  <= pending_d;
      rr_q       <= rr_d;
      valid_q    <= valid_d;
      ch_q       <= ch_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_sw_debounced = deb_q;
  assign o_evt_valid    = valid_q;
  assign o_evt_ch       = ch_q;
  assign o_evt_level    = level_q;
  assign o_evt_overflow = ovf_q;

`ifdef DEBOUNCE_SCAN_TIMESTAMP_EN
  logic [15:0]            ts_q, ts_d;
  logic [N_CH-1:0][15:0]  cap_q, cap_d;
  logic [15:0]            evt_time_q, evt_time_d;

  always_comb begin
    ts_d = ts_q + 16'(tick);
    for (int c = 0; c < N_CH; c++) begin
      cap_d[c] = chg[c] ? ts_q : cap_q[c];
    end
    // The granted event carries the capture taken before any same-cycle overwrite.
    evt_time_d = load ? cap_q[grant] : evt_time_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ts_q       <= '0;
      cap_q      <= '0;
      evt_time_q <= '0;
    end else begin
      ts_q       <= ts_d;
      cap_q      <= cap_d;
      evt_time_q <= evt_time_d;
    end
  end

  assign o_evt_time = evt_time_q;
`endif

endmodule
